// File: rtl/sll_pkg.sv
// Shared types for the singly-linked-list arbiter: list op codes, FSM states, NULL-address test.
package sll_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_DELETE_VALUE = 2'd1,
    OP_PUSH_BACK    = 2'd2,
    OP_PUSH_FRONT   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the low `width` bits of addr are all ones (the list's NULL pointer).
  function automatic logic is_null_addr(input logic [31:0] addr, input int unsigned width);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width) && !addr[i]) res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sll_arbiter.sv
// Round-robin front end sharing one singly-linked list between NUM_REQ requesters.
// Define SLL_ARB_PRECHECK_EN to reject ops the list status says must fail, without issuing them.
module sll_arbiter
  import sll_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  parameter int ADDR_WIDTH = $clog2(MAX_NODE + 1),
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rsp_next_addr,
  output logic                          rsp_fault,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [DATA_WIDTH-1:0]         ll_data_in,
  output logic [ADDR_WIDTH-1:0]         ll_addr_in,
  output logic [1:0]                    ll_op,
  output logic                          ll_op_start,
  input  logic [DATA_WIDTH-1:0]         ll_data_out,
  input  logic [ADDR_WIDTH-1:0]         ll_next_node_addr,
  input  logic                          ll_op_done,
  input  logic                          ll_full,
  input  logic                          ll_empty,
  input  logic                          ll_fault
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [GW-1:0]           rr_q, rr_d, gid_q, gid_d;
  op_e                     op_q, op_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d, rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, rsp_next_q, rsp_next_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    fault_q, fault_d;

  logic [NUM_REQ-1:0]      gnt;
  logic [GW-1:0]           gnt_idx;
  logic                    gnt_vld;
  op_e                     sel_op;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    reject;
  logic [NUM_REQ-1:0]      ready_raw;

  rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign sel_op   = op_e'(req_op[int'(gnt_idx)*2 +: 2]);
  assign sel_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef SLL_ARB_PRECHECK_EN
  always_comb begin
    reject = 1'b0;
    if ((sel_op == OP_PUSH_BACK || sel_op == OP_PUSH_FRONT) && ll_full) reject = 1'b1;
    if ((sel_op == OP_READ || sel_op == OP_DELETE_VALUE) && ll_empty) reject = 1'b1;
    if (sel_op == OP_READ && is_null_addr(32'(sel_addr), ADDR_WIDTH)) reject = 1'b1;
  end
`else
  logic unused_status;
  assign unused_status = ll_full ^ ll_empty;
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gid_d       = gid_q;
    op_d        = op_q;
    data_d      = data_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    rsp_data_d  = rsp_data_q;
    rsp_next_d  = rsp_next_q;
    fault_d     = fault_q;
    ready_raw   = '0;
    rsp_valid   = '0;
    ll_op_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          ready_raw = gnt;
          gid_d     = gnt_idx;
          op_d      = sel_op;
          data_d    = sel_data;
          addr_d    = sel_addr;
          timer_d   = '0;
          rr_d      = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          fault_d   = reject;
          state_d   = reject ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        ll_op_start = 1'b1;
        if (ll_op_done) begin
          rsp_data_d = ll_data_out;
          rsp_next_d = ll_next_node_addr;
          fault_d    = ll_fault;
          state_d    = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid[gid_q] = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset state is IDLE, so the grant must also be masked while reset is held.
  assign req_ready     = ready_raw & {NUM_REQ{rst}};
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = gid_q;
  assign ll_op         = op_q;
  assign ll_data_in    = data_q;
  assign ll_addr_in    = addr_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_next_addr = rsp_next_q;
  assign rsp_fault     = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      gid_q      <= '0;
      op_q       <= OP_READ;
      data_q     <= '0;
      addr_q     <= '0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_next_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gid_q      <= gid_d;
      op_q       <= op_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_next_q <= rsp_next_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_sll_arbiter.sv
// Directed bench for sll_arbiter with a small behavioural list model behind it.
module tb_sll_arbiter;

  localparam int NR = 4;
  localparam int TO = 64;
  localparam int LAT = 3;
  localparam logic [3:0] NULLA = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [15:0] req_addr;
  logic [7:0]  rsp_data, ll_data_in, ll_data_out;
  logic [3:0]  rsp_next_addr, ll_addr_in, ll_next_node_addr;
  logic        rsp_fault, busy, ll_op_start, ll_op_done, ll_full, ll_empty, ll_fault;
  logic [1:0]  grant_id, ll_op;

  int n_cmp = 0;
  int n_bad = 0;
  bit hang = 1'b0;

  always #5 clk = ~clk;

  sll_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_next_addr(rsp_next_addr), .rsp_fault(rsp_fault), .busy(busy), .grant_id(grant_id),
    .ll_data_in(ll_data_in), .ll_addr_in(ll_addr_in), .ll_op(ll_op), .ll_op_start(ll_op_start),
    .ll_data_out(ll_data_out), .ll_next_node_addr(ll_next_node_addr), .ll_op_done(ll_op_done),
    .ll_full(ll_full), .ll_empty(ll_empty), .ll_fault(ll_fault)
  );

  // List model: node i holds the i-th element, op_done LAT cycles into op_start.
  logic [7:0] mem [8];
  int cnt, bcnt;

  always_comb begin
    ll_full           = (cnt == 8);
    ll_empty          = (cnt == 0);
    ll_op_done        = ll_op_start && !hang && (bcnt == LAT - 1);
    ll_data_out       = '0;
    ll_next_node_addr = NULLA;
    ll_fault          = 1'b0;
    case (ll_op)
      2'd0: begin
        if (int'(ll_addr_in) < cnt) begin
          ll_data_out = mem[ll_addr_in[2:0]];
          if (int'(ll_addr_in) != cnt - 1) ll_next_node_addr = ll_addr_in + 4'd1;
        end else ll_fault = 1'b1;
      end
      2'd1: begin
        ll_fault = 1'b1;
        for (int i = 0; i < 8; i++) if (i < cnt && mem[i] == ll_data_in) ll_fault = 1'b0;
      end
      default: ll_fault = ll_full;
    endcase
  end

  always @(posedge clk or negedge rst) begin : model_seq
    int j;
    if (!rst) begin
      cnt  <= 0;
      bcnt <= 0;
    end else begin
      bcnt <= (ll_op_start && !ll_op_done) ? bcnt + 1 : 0;
      if (ll_op_done && !ll_fault) begin
        case (ll_op)
          2'd2: begin mem[cnt[2:0]] <= ll_data_in; cnt <= cnt + 1; end
          2'd3: begin
            for (int i = 1; i < 8; i++) mem[i] <= mem[i-1];
            mem[0] <= ll_data_in;
            cnt <= cnt + 1;
          end
          2'd1: begin
            j = 8;
            for (int i = 0; i < 8; i++) if (j == 8 && i < cnt && mem[i] == ll_data_in) j = i;
            for (int i = 0; i < 7; i++) if (i >= j) mem[i] <= mem[i+1];
            cnt <= cnt - 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Issues one request and waits (bounded) for its response; lat counts cycles from accept edge.
  task automatic do_op(input int r, input logic [1:0] op, input logic [7:0] d, input logic [3:0] a,
                       output logic ok, output int lat, output logic started,
                       output logic [7:0] rd, output logic [3:0] rn, output logic flt);
    ok = 1'b0; lat = 0; started = 1'b0; rd = '0; rn = '0; flt = 1'b0;
    @(negedge clk);
    req_op[2*r +: 2] = op; req_data[8*r +: 8] = d; req_addr[4*r +: 4] = a; req_valid[r] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready[r]) break;
      @(negedge clk);
    end
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      #1;
      if (ll_op_start) started = 1'b1;
      if (rsp_valid != 0) begin
        ok = (rsp_valid == (4'b1 << r)); lat = n; rd = rsp_data; rn = rsp_next_addr; flt = rsp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if ({busy, ll_op_start, rsp_valid} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: busy/start/rsp got %b want 0", {busy, ll_op_start, rsp_valid}); end
    n_cmp++; if ({grant_id, rsp_data, rsp_fault, ll_op} !== 13'b0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", {grant_id, rsp_data, rsp_fault, ll_op}); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_push_back();
    do_reset();
    @(negedge clk);
    req_op[3:2] = 2'd2; req_data[15:8] = 8'h12; req_valid[1] = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL push_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if ({ll_op_start, ll_op, ll_data_in} !== {1'b1, 2'd2, 8'h12}) begin
        n_bad++; $display("FAIL push_issue_T+%0d: start/op/data got %b/%0d/%h want 1/2/12", c, ll_op_start, ll_op, ll_data_in);
      end
      @(negedge clk); #1;
    end
    n_cmp++; if ({rsp_valid, rsp_fault, ll_op_start} !== {4'b0010, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL push_rsp_T+4: rsp/fault/start got %b/%b/%b want 0010/0/0", rsp_valid, rsp_fault, ll_op_start);
    end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL push_idle_T+5: busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < NR; i++) begin req_op[2*i +: 2] = 2'd2; req_data[8*i +: 8] = 8'(8'h30 + i); end
    req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = k % NR;
      for (int i = 0; i < 50 && req_ready == 0; i++) begin @(negedge clk); #1; end
      n_cmp++; if (req_ready !== (4'b1 << exp)) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, 4'b1 << exp); end
      @(negedge clk); #1;
      for (int i = 0; i < 50 && rsp_valid == 0; i++) begin @(negedge clk); #1; end
      n_cmp++; if ({rsp_valid, grant_id} !== {4'b1 << exp, 2'(exp)}) begin
        n_bad++; $display("FAIL rr_rsp_%0d: rsp/id got %b/%0d want %b/%0d", k, rsp_valid, grant_id, 4'b1 << exp, exp);
      end
      @(negedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_read();
    logic ok, st, f; int lat; logic [7:0] rd; logic [3:0] rn;
    logic [7:0] vals [3] = '{8'hA1, 8'hB2, 8'hC3};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(0, 2'd2, vals[i], 4'd0, ok, lat, st, rd, rn, f);
      n_cmp++; if ({ok, f} !== 2'b10) begin n_bad++; $display("FAIL read_setup_push%0d: ok/fault got %b/%b want 1/0", i, ok, f); end
    end
    do_op(2, 2'd0, 8'h00, 4'd2, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, rd, rn} !== {1'b1, 1'b0, 8'hC3, NULLA}) begin
      n_bad++; $display("FAIL read_tail: ok/fault/data/next got %b/%b/%h/%h want 1/0/c3/f", ok, f, rd, rn);
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL read_latency: got %0d want 4", lat); end
    do_op(3, 2'd0, 8'h00, 4'd0, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, rd, rn} !== {1'b1, 1'b0, 8'hA1, 4'd1}) begin
      n_bad++; $display("FAIL read_head: ok/fault/data/next got %b/%b/%h/%h want 1/0/a1/1", ok, f, rd, rn);
    end
  endtask

  task automatic test_full_empty();
    logic ok, st, f; int lat, nf; logic [7:0] rd; logic [3:0] rn;
`ifdef SLL_ARB_PRECHECK_EN
    logic exp_st = 1'b0; int exp_lat = 1;
`else
    logic exp_st = 1'b1; int exp_lat = 4;
`endif
    do_reset();
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      do_op(3, 2'd2, 8'(i), 4'd0, ok, lat, st, rd, rn, f);
      if (!ok || f) nf++;
    end
    n_cmp++; if (nf !== 0) begin n_bad++; $display("FAIL fill_pushes: bad responses got %0d want 0", nf); end
    do_op(3, 2'd2, 8'h99, 4'd0, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, st} !== {1'b1, 1'b1, exp_st}) begin
      n_bad++; $display("FAIL ninth_push: ok/fault/start got %b/%b/%b want 1/1/%b", ok, f, st, exp_st);
    end
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL ninth_push_lat: got %0d want %0d", lat, exp_lat); end
    do_reset();
    do_op(0, 2'd0, 8'h00, 4'd0, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, st} !== {1'b1, 1'b1, exp_st}) begin
      n_bad++; $display("FAIL read_empty: ok/fault/start got %b/%b/%b want 1/1/%b", ok, f, st, exp_st);
    end
    do_op(1, 2'd2, 8'h55, 4'd0, ok, lat, st, rd, rn, f);
    do_op(1, 2'd0, 8'h00, NULLA, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, st} !== {1'b1, 1'b1, exp_st}) begin
      n_bad++; $display("FAIL read_null: ok/fault/start got %b/%b/%b want 1/1/%b", ok, f, st, exp_st);
    end
  endtask

  task automatic test_timeout();
    logic ok, st, f; int lat; logic [7:0] rd; logic [3:0] rn;
    do_reset();
    hang = 1'b1;
    do_op(1, 2'd2, 8'h44, 4'd0, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, st} !== 3'b111) begin n_bad++; $display("FAIL timeout_rsp: ok/fault/start got %b/%b/%b want 1/1/1", ok, f, st); end
    n_cmp++; if (lat !== TO + 1) begin n_bad++; $display("FAIL timeout_lat: got %0d want %0d", lat, TO + 1); end
    hang = 1'b0;
    do_op(2, 2'd2, 8'h45, 4'd0, ok, lat, st, rd, rn, f);
    n_cmp++; if ({ok, f, lat} !== {1'b1, 1'b0, 32'd4}) begin
      n_bad++; $display("FAIL after_timeout: ok/fault/lat got %b/%b/%0d want 1/0/4", ok, f, lat);
    end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    do_reset();
    hang = 1'b1;
    @(negedge clk);
    req_op[5:4] = 2'd2; req_data[23:16] = 8'h77; req_valid[2] = 1'b1;
    #1;
    for (int i = 0; i < 20 && !req_ready[2]; i++) begin @(negedge clk); #1; end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    n_cmp++; if ({busy, ll_op_start} !== 2'b11) begin n_bad++; $display("FAIL pre_abort_busy: busy/start got %b%b want 11", busy, ll_op_start); end
    rst = 1'b0; req_valid = '1;
    #1;
    n_cmp++; if ({ll_op_start, busy, req_ready, rsp_valid} !== 10'b0) begin
      n_bad++; $display("FAIL abort_outputs: start/busy/ready/rsp got %b/%b/%b/%b want 0", ll_op_start, busy, req_ready, rsp_valid);
    end
    req_valid = '0; hang = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); #1; if (rsp_valid != 0) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_rsp: responses got %0d want 0", seen); end
    @(negedge clk);
    req_op = '0; req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL abort_rr_restart: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0; req_op = '0; req_data = '0; req_addr = '0;
    test_reset();
    test_push_back();
    test_round_robin();
    test_read();
    test_full_empty();
    test_timeout();
    test_reset_mid_busy();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
